// File: rtl/plic_arb_sched_pkg.sv
// Shared PLIC arbitration-scheduler definitions: FSM state encodings and
// default sizing for the context time-sharing slice.
package plic_arb_sched_pkg;

  localparam int CTX_NUM_DEF  = 4;
  localparam int TOUT_CYC_DEF = 63;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_REQ   = 2'd1,
    SCHED_RUN   = 2'd2,
    SCHED_ABORT = 2'd3
  } sched_state_e;

endpackage

// File: rtl/plic_arb_sched_if.sv
// Context/arbiter handshake bundle of the PLIC arbitration scheduler.
// The slave side is the scheduler; the master side is its environment.
interface plic_arb_sched_if
  import plic_arb_sched_pkg::*;
#(
  parameter int CTX_NUM = CTX_NUM_DEF,
  parameter int CTX_BIT = $clog2(CTX_NUM)
);

  logic [CTX_NUM-1:0] ctx_sched_start;
  logic [CTX_NUM-1:0] ctx_sched_flush;
  logic               arb_sched_start_ack;
  logic               arb_sched_done;
  logic               sched_arb_start;
  logic               sched_arb_flush;
  logic [CTX_BIT-1:0] sched_arb_ctx_sel;
  logic [CTX_NUM-1:0] sched_ctx_start_ack;
  logic [CTX_NUM-1:0] sched_ctx_done;
  logic               sched_busy;
  logic               sched_tout_err;

  modport slave (
    input  ctx_sched_start, ctx_sched_flush, arb_sched_start_ack, arb_sched_done,
    output sched_arb_start, sched_arb_flush, sched_arb_ctx_sel,
           sched_ctx_start_ack, sched_ctx_done, sched_busy, sched_tout_err
  );

  modport master (
    output ctx_sched_start, ctx_sched_flush, arb_sched_start_ack, arb_sched_done,
    input  sched_arb_start, sched_arb_flush, sched_arb_ctx_sel,
           sched_ctx_start_ack, sched_ctx_done, sched_busy, sched_tout_err
  );

endinterface

// File: rtl/plic_arb_sched_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// from ptr_i with wrap-around (CTX_NUM is a power of two).
module plic_rr_pick
  import plic_arb_sched_pkg::*;
#(
  parameter int CTX_NUM = CTX_NUM_DEF,
  parameter int CTX_BIT = $clog2(CTX_NUM)
) (
  input  logic [CTX_NUM-1:0] req_i,
  input  logic [CTX_BIT-1:0] ptr_i,
  output logic               valid_o,
  output logic [CTX_BIT-1:0] idx_o
);

  logic [CTX_BIT-1:0] cand_s;

  // Scan from the farthest offset down so the nearest candidate is the last write.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand_s  = '0;
    for (int i = CTX_NUM - 1; i >= 0; i--) begin
      cand_s  = ptr_i + CTX_BIT'(i);
      valid_o = req_i[cand_s] ? 1'b1   : valid_o;
      idx_o   = req_i[cand_s] ? cand_s : idx_o;
    end
  end

endmodule

// File: rtl/plic_arb_sched.sv
// Time-shares one PLIC arbitration slice among CTX_NUM hart contexts:
// round-robin grant, start/flush handshake to the arbiter, watchdog abort.
module plic_arb_sched
  import plic_arb_sched_pkg::*;
#(
  parameter int CTX_NUM  = CTX_NUM_DEF,
  parameter int CTX_BIT  = $clog2(CTX_NUM),
  parameter int TOUT_CYC = TOUT_CYC_DEF
) (
  input  logic            arb_ctrl_clk,
  input  logic            plicrst_b,
  plic_arb_sched_if.slave bus_if
);

  localparam int WDOG_W = $clog2(TOUT_CYC + 1);

  sched_state_e       state_q, state_d;
  logic [CTX_NUM-1:0] pending_q, pending_d;
  logic [CTX_BIT-1:0] owner_q, owner_d;
  logic [CTX_BIT-1:0] rr_ptr_q, rr_ptr_d;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;
  logic               flush_q, flush_d;
  logic               tout_err_q, tout_err_d;

  logic               pick_valid_s;
  logic [CTX_BIT-1:0] pick_idx_s;
  logic [CTX_NUM-1:0] grant_s;
  logic [CTX_NUM-1:0] owner_oh_s;
  logic               own_flush_s;
  logic [CTX_NUM-1:0] start_ack_s;
  logic [CTX_NUM-1:0] done_s;

  plic_rr_pick #(
    .CTX_NUM (CTX_NUM),
    .CTX_BIT (CTX_BIT)
  ) u_rr_pick (
    .req_i   (pending_q),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid_s),
    .idx_o   (pick_idx_s)
  );

  // Owner one-hot and owner-flush detection.
  always_comb begin
    owner_oh_s          = '0;
    owner_oh_s[owner_q] = 1'b1;
    own_flush_s         = |(bus_if.ctx_sched_flush & owner_oh_s);
  end

  // Scheduler FSM next-state, grant and per-context pulse decode.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    wdog_d      = wdog_q;
    flush_d     = 1'b0;
    tout_err_d  = tout_err_q;
    grant_s     = '0;
    start_ack_s = '0;
    done_s      = '0;
    case (state_q)
      SCHED_IDLE: begin
        if (pick_valid_s) begin
          grant_s[pick_idx_s] = 1'b1;
          owner_d             = pick_idx_s;
          rr_ptr_d            = pick_idx_s + CTX_BIT'(1);
          state_d             = SCHED_REQ;
        end else begin
          state_d = SCHED_IDLE;
        end
      end
      SCHED_REQ: begin
        if (own_flush_s) begin
          flush_d = 1'b1;
          state_d = SCHED_IDLE;
        end else if (bus_if.arb_sched_start_ack) begin
          start_ack_s = owner_oh_s;
          wdog_d      = '0;
          state_d     = SCHED_RUN;
        end else begin
          state_d = SCHED_REQ;
        end
      end
      SCHED_RUN: begin
        // Owner flush beats done, done beats the watchdog.
        if (own_flush_s) begin
          flush_d = 1'b1;
          state_d = SCHED_IDLE;
        end else if (bus_if.arb_sched_done) begin
          done_s  = owner_oh_s;
          state_d = SCHED_IDLE;
        end else if (wdog_q == WDOG_W'(TOUT_CYC)) begin
          tout_err_d = 1'b1;
          state_d    = SCHED_ABORT;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      SCHED_ABORT: begin
        state_d = SCHED_IDLE;
      end
      default: begin
        state_d = SCHED_IDLE;
      end
    endcase
  end

  // Pending bits: a start arriving with a grant re-arms; flush beats start.
  always_comb begin
    pending_d = ((pending_q & ~grant_s) | bus_if.ctx_sched_start) & ~bus_if.ctx_sched_flush;
  end

  // Scheduler state registers.
  always_ff @(posedge arb_ctrl_clk or negedge plicrst_b) begin
    if (!plicrst_b) begin
      state_q    <= SCHED_IDLE;
      pending_q  <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      wdog_q     <= '0;
      flush_q    <= 1'b0;
      tout_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      wdog_q     <= wdog_d;
      flush_q    <= flush_d;
      tout_err_q <= tout_err_d;
    end
  end

  assign bus_if.sched_arb_start     = (state_q == SCHED_REQ);
  assign bus_if.sched_arb_flush     = flush_q | (state_q == SCHED_ABORT);
  assign bus_if.sched_arb_ctx_sel   = owner_q;
  assign bus_if.sched_ctx_start_ack = start_ack_s;
  assign bus_if.sched_ctx_done      = done_s;
  assign bus_if.sched_busy          = (state_q != SCHED_IDLE);
  assign bus_if.sched_tout_err      = tout_err_q;

endmodule

// File: tb/tb_plic_arb_sched.sv
// Randomized and directed bench for plic_arb_sched against a per-cycle
// behavioural model of the context scheduling rules.
module tb_plic_arb_sched;

  localparam int N    = 4;
  localparam int TOUT = 63;
  localparam int PH_IDLE = 0, PH_REQ = 1, PH_RUN = 2, PH_ABORT = 3;

  logic clk = 1'b0;
  logic plicrst_b = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  plic_arb_sched_if #(.CTX_NUM(N)) bus ();

  plic_arb_sched #(.CTX_NUM(N), .TOUT_CYC(TOUT)) dut (
    .arb_ctrl_clk (clk),
    .plicrst_b    (plicrst_b),
    .bus_if       (bus)
  );

  always #5 clk = ~clk;

  // Reference model: what the scheduler holds between clock edges.
  bit [N-1:0] m_pend;
  int         m_owner, m_rr, m_phase, m_wd;
  bit         m_flush_next, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_owner = 0; m_rr = 0; m_phase = PH_IDLE;
    m_wd = 0; m_flush_next = 1'b0; m_err = 1'b0;
  endtask

  task automatic drive(input logic [N-1:0] st, input logic [N-1:0] fl, input logic ak, input logic dn);
    bus.ctx_sched_start     = st;
    bus.ctx_sched_flush     = fl;
    bus.arb_sched_start_ack = ak;
    bus.arb_sched_done      = dn;
  endtask

  // Compare all outputs with the model given the current inputs.
  task automatic compare(input logic [N-1:0] fl, input logic ak, input logic dn);
    bit own_fl;
    logic [31:0] e_ack, e_done;
    own_fl = fl[m_owner];
    e_ack  = (m_phase == PH_REQ && ak && !own_fl) ? (32'd1 << m_owner) : 32'd0;
    e_done = (m_phase == PH_RUN && dn && !own_fl) ? (32'd1 << m_owner) : 32'd0;
    chk("arb_start", 32'(bus.sched_arb_start), 32'(m_phase == PH_REQ));
    chk("arb_flush", 32'(bus.sched_arb_flush), 32'(m_flush_next || m_phase == PH_ABORT));
    chk("ctx_sel",   32'(bus.sched_arb_ctx_sel), 32'(m_owner));
    chk("start_ack", 32'(bus.sched_ctx_start_ack), e_ack);
    chk("ctx_done",  32'(bus.sched_ctx_done), e_done);
    chk("busy",      32'(bus.sched_busy), 32'(m_phase != PH_IDLE));
    chk("tout_err",  32'(bus.sched_tout_err), 32'(m_err));
  endtask

  // Advance the model across one rising edge.
  task automatic model_step(input logic [N-1:0] st, input logic [N-1:0] fl, input logic ak, input logic dn);
    int winner;
    bit own_fl;
    bit [N-1:0] np;
    own_fl = fl[m_owner];
    winner = -1;
    if (m_phase == PH_IDLE) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (m_pend[idx] && winner < 0) winner = idx;
      end
    end
    for (int i = 0; i < N; i++) begin
      np[i] = (m_pend[i] && i != winner) || st[i];
      if (fl[i]) np[i] = 1'b0;
    end
    m_flush_next = 1'b0;
    case (m_phase)
      PH_IDLE: if (winner >= 0) begin
        m_owner = winner; m_rr = (winner + 1) % N; m_phase = PH_REQ;
      end
      PH_REQ: begin
        if (own_fl) begin m_flush_next = 1'b1; m_phase = PH_IDLE; end
        else if (ak) begin m_phase = PH_RUN; m_wd = 0; end
      end
      PH_RUN: begin
        if (own_fl) begin m_flush_next = 1'b1; m_phase = PH_IDLE; end
        else if (dn) m_phase = PH_IDLE;
        else if (m_wd == TOUT) begin m_phase = PH_ABORT; m_err = 1'b1; end
        else m_wd++;
      end
      default: m_phase = PH_IDLE;
    endcase
    m_pend = np;
  endtask

  task automatic cyc(input logic [N-1:0] st, input logic [N-1:0] fl, input logic ak, input logic dn);
    @(negedge clk);
    drive(st, fl, ak, dn);
    #1;
    compare(fl, ak, dn);
    model_step(st, fl, ak, dn);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, '0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic async_reset();
    @(negedge clk);
    drive('0, '0, 1'b0, 1'b0);
    #2 plicrst_b = 1'b0;
    #1;
    model_reset();
    compare('0, 1'b0, 1'b0);
    @(negedge clk);
    plicrst_b = 1'b1;
  endtask

  initial begin
    model_reset();
    drive('0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    compare('0, 1'b0, 1'b0);
    plicrst_b = 1'b1;

    // Single start on ctx 2: REQ two cycles later, ack and done to ctx 2.
    cyc(4'b0100, '0, 1'b0, 1'b0);
    idle(2);
    chk("sel_ctx2", 32'(bus.sched_arb_ctx_sel), 32'd2);
    cyc('0, '0, 1'b1, 1'b0);
    idle(2);
    cyc('0, '0, 1'b0, 1'b1);
    idle(1);

    // Simultaneous starts on 0,1,3 with rr_ptr at 3: each RUN closed by done.
    cyc(4'b1011, '0, 1'b0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      idle(2);
      cyc('0, '0, 1'b1, 1'b0);
      idle(1);
      cyc('0, '0, 1'b0, 1'b1);
    end
    idle(2);

    // Owner flushed in RUN together with done: no done pulse, flush next cycle.
    cyc(4'b0010, '0, 1'b0, 1'b0);
    idle(2);
    cyc('0, '0, 1'b1, 1'b0);
    cyc('0, 4'b0010, 1'b0, 1'b1);
    idle(3);

    // Start and flush together on ctx 0: never granted.
    cyc(4'b0001, 4'b0001, 1'b0, 1'b0);
    idle(3);

    // Withheld done: watchdog abort, then ctx 3 is served.
    cyc(4'b0001, '0, 1'b0, 1'b0);
    idle(2);
    cyc(4'b1000, '0, 1'b1, 1'b0);
    idle(70);
    cyc('0, '0, 1'b1, 1'b0);
    cyc('0, '0, 1'b0, 1'b1);
    idle(2);

    // Owner restarts during RUN while ctx 2 waits: ctx 2 goes first.
    cyc(4'b0001, '0, 1'b0, 1'b0);
    idle(2);
    cyc('0, '0, 1'b1, 1'b0);
    cyc(4'b0101, '0, 1'b0, 1'b0);
    cyc('0, '0, 1'b0, 1'b1);
    idle(2);
    chk("sel_ctx2_first", 32'(bus.sched_arb_ctx_sel), 32'd2);
    cyc('0, '0, 1'b1, 1'b0);
    cyc('0, '0, 1'b0, 1'b1);
    idle(3);

    // Randomized traffic with a mid-run asynchronous reset.
    for (int r = 0; r < 3000; r++) begin
      logic [N-1:0] st, fl;
      st = N'($urandom) & N'($urandom);
      fl = ($urandom_range(0, 15) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      cyc(st, fl, ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0));
      if (r == 1500) async_reset();
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
